// File: rtl/irq_sched_if.sv
// Interrupt scheduler bus: peripheral sources, config port, and counter handshake.
// master = software/counter side, slave = scheduler.
interface irq_sched_if;
    logic [6:0] src;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic [7:0] cfg_rdata;
    logic       inter;
    logic       eirq;
    logic       irq1;
    logic       irq2;
    logic       irq3;
    logic       busy;
    logic [2:0] active_id;

    modport master (
        output src, cfg_we, cfg_addr, cfg_wdata, inter, eirq,
        input  cfg_rdata, irq1, irq2, irq3, busy, active_id
    );

    modport slave (
        input  src, cfg_we, cfg_addr, cfg_wdata, inter, eirq,
        output cfg_rdata, irq1, irq2, irq3, busy, active_id
    );
endinterface

// File: rtl/irq_sched.sv
// Interrupt scheduler: latches/masks up to 7 sources, requests code 1..7 until inter, blocks until eirq.
// Latency src->pending 1 cycle, pending->code 1 cycle; IRQ_SCHED_RR_EN selects rotating priority (default fixed, highest wins).
module irq_sched #(
    parameter int N_SRC = 7
) (
    input  logic           clk,
    input  logic           rst,
    irq_sched_if.slave     bus
);
    localparam logic [6:0] VALID = 7'((8'd1 << N_SRC) - 8'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    state_t     state;
    logic [6:0] mask;
    logic [6:0] mode;
    logic [6:0] pending;
    logic [6:0] src_q;
    logic [2:0] code;
    logic       busy;
    logic [2:0] active_id;

    logic [6:0] set_vec;
    logic [6:0] clr_vec;
    logic [6:0] eligible;
    logic [2:0] win;
    logic [7:0] rdata;
    logic       unused_bits;

`ifdef IRQ_SCHED_RR_EN
    logic [2:0] last;
    logic [3:0] idx;
    logic       found;
`endif

    assign unused_bits = bus.cfg_wdata[7];
    assign eligible    = pending & ~mask;

    always_comb begin
        set_vec = '0;
        for (int i = 0; i < 7; i++) begin
            set_vec[i] = mode[i] ? (bus.src[i] & ~src_q[i]) : bus.src[i];
        end
        set_vec = set_vec & VALID;
    end

    // Set events win over both clears, so an edge arriving on the accept cycle survives.
    always_comb begin
        clr_vec = '0;
        if (bus.cfg_we && bus.cfg_addr == 2'd2) begin
            clr_vec = bus.cfg_wdata[6:0];
        end
        if (state == REQ && bus.inter) begin
            clr_vec = clr_vec | (7'd1 << (active_id - 3'd1));
        end
    end

`ifdef IRQ_SCHED_RR_EN
    // Search upward from the slot after the last served one, wrapping to index 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = 4'(last) + 4'd1 + 4'(k);
            if (idx >= 4'(N_SRC)) begin
                idx = idx - 4'(N_SRC);
            end
            if (!found && eligible[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eligible[i]) begin
                win = 3'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            mask      <= VALID;
            mode      <= '0;
            pending   <= '0;
            src_q     <= '0;
            code      <= '0;
            busy      <= 1'b0;
            active_id <= '0;
`ifdef IRQ_SCHED_RR_EN
            last      <= '0;
`endif
        end else begin
            src_q   <= bus.src & VALID;
            pending <= (pending & ~clr_vec) | set_vec;
            if (bus.cfg_we && bus.cfg_addr == 2'd0) begin
                mask <= bus.cfg_wdata[6:0] & VALID;
            end
            if (bus.cfg_we && bus.cfg_addr == 2'd1) begin
                mode <= bus.cfg_wdata[6:0] & VALID;
            end
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state     <= REQ;
                        active_id <= win + 3'd1;
                        code      <= win + 3'd1;
                        busy      <= 1'b1;
                    end
                end
                // The request is committed: mask or W1C changes here cannot withdraw it.
                REQ: begin
                    if (bus.inter) begin
                        state <= SERV;
                        code  <= '0;
`ifdef IRQ_SCHED_RR_EN
                        last  <= active_id - 3'd1;
`endif
                    end
                end
                SERV: begin
                    if (bus.eirq) begin
                        state     <= IDLE;
                        active_id <= '0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    code      <= '0;
                    busy      <= 1'b0;
                    active_id <= '0;
                end
            endcase
        end
    end

    always_comb begin
        case (bus.cfg_addr)
            2'd0:    rdata = {1'b0, mask};
            2'd1:    rdata = {1'b0, mode};
            2'd2:    rdata = {1'b0, pending};
            default: rdata = {busy, state, 2'b00, active_id};
        endcase
    end

    assign bus.cfg_rdata = rdata;
    assign bus.irq1      = code[0];
    assign bus.irq2      = code[1];
    assign bus.irq3      = code[2];
    assign bus.busy      = busy;
    assign bus.active_id = active_id;
endmodule
